// File: rtl/neorv32_wb_arbiter.sv
// rtl/neorv32_wb_arbiter.sv - round-robin Wishbone arbiter with bus-timeout watchdog
//
// Shares one classic Wishbone slave port between NUM_MASTERS masters. A master
// requests by raising cyc and stb. In IDLE the arbiter grants the first requester
// found searching upward from the last granted master, with wrap-around.
//
// The granted master is routed combinationally to the slave, and the slave's
// ack/err is routed combinationally back to that master. A watchdog raises a
// one-cycle err to the granted master when its strobe goes unanswered for
// TIMEOUT cycles. The arbiter always spends one idle cycle between two grants.
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   m_cyc_i/stb_i/we_i     per-master control, one bit per master
//   m_sel_i/adr_i/dat_i    per-master fields, master k in slice k
//   m_dat_o                slave read data, broadcast to all masters
//   m_ack_o/m_err_o        response, only the granted master's bit can be set
//   s_cyc_o ... s_dat_o    slave request port
//   s_dat_i/ack_i/err_i    slave response port
//   grant_o                one-hot current grant, zero while idle
module neorv32_wb_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 255,
    parameter int LOCK_ON_CYC = 1
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_i,
    output logic [DATA_W-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [DATA_W/8-1:0]             s_sel_o,
    output logic [ADDR_W-1:0]               s_adr_o,
    output logic [DATA_W-1:0]               s_dat_o,
    input  logic [DATA_W-1:0]               s_dat_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    output logic [NUM_MASTERS-1:0]          grant_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       tmo_cnt_q, tmo_cnt_d;

    logic [NUM_MASTERS-1:0] req;
    logic                   busy;
    logic                   g_cyc, g_stb;
    logic                   tmo_hit;
    logic                   resp_ack, resp_err;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;

    assign req  = m_cyc_i & m_stb_i;
    assign busy = (state_q == BUSY);

    assign g_cyc = m_cyc_i[gidx_q];
    assign g_stb = m_stb_i[gidx_q];

    // Timeout fires on the TIMEOUT-th unanswered strobe cycle. A response in
    // the same cycle takes precedence, so a late-but-in-time ack is never
    // turned into an error.
    assign tmo_hit = (TIMEOUT != 0) && busy && g_cyc && g_stb && !s_ack_i && !s_err_i &&
                     (tmo_cnt_q == TMO_LAST);

    // Gating with cyc means a master that drops cyc aborts the slave cycle at
    // once and never receives the stale response.
    assign s_cyc_o = busy & g_cyc;
    assign s_stb_o = busy & g_cyc & g_stb & ~tmo_hit;
    assign s_we_o  = busy & m_we_i[gidx_q];
    assign s_sel_o = busy ? m_sel_i[gidx_q*SEL_W +: SEL_W]   : '0;
    assign s_adr_o = busy ? m_adr_i[gidx_q*ADDR_W +: ADDR_W] : '0;
    assign s_dat_o = busy ? m_dat_i[gidx_q*DATA_W +: DATA_W] : '0;

    assign resp_ack = s_cyc_o & s_ack_i;
    assign resp_err = s_cyc_o & (s_err_i | tmo_hit);

    assign m_ack_o = resp_ack ? grant_q : '0;
    assign m_err_o = resp_err ? grant_q : '0;
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    // Round-robin pick: first requester after the last granted master.
    always_comb begin
        int cand;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    gidx_d  = pick_idx;
                    grant_d = NUM_MASTERS'(1) << pick_idx;
                end
            end
            BUSY: begin
                if (!g_cyc || ((LOCK_ON_CYC == 0) && (resp_ack || resp_err))) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (!busy || resp_ack || resp_err) begin
            tmo_cnt_d = '0;
        end else if (s_stb_o) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= IDX_W'(NUM_MASTERS - 1);
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_neorv32_wb_arbiter.sv
// tb/tb_neorv32_wb_arbiter.sv - directed self-checking bench for neorv32_wb_arbiter
module tb_neorv32_wb_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [7:0]  m_sel;
    logic [63:0] m_adr, m_dat;
    logic [31:0] s_dat_i;
    logic        s_ack, s_err;

    logic [31:0] m_dat_o, s_adr_o, s_dat_o;
    logic [1:0]  m_ack_o, m_err_o, grant_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;

    logic [31:0] m_dat_nl, s_adr_nl, s_dat_nl;
    logic [1:0]  m_ack_nl, m_err_nl, grant_nl;
    logic        s_cyc_nl, s_stb_nl, s_we_nl;
    logic [3:0]  s_sel_nl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    neorv32_wb_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .LOCK_ON_CYC(1)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant_o)
    );

    neorv32_wb_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .LOCK_ON_CYC(0)) dut_nl (
        .clk_i(clk), .rstn_i(rstn),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_nl),
        .m_ack_o(m_ack_nl), .m_err_o(m_err_nl),
        .s_cyc_o(s_cyc_nl), .s_stb_o(s_stb_nl), .s_we_o(s_we_nl), .s_sel_o(s_sel_nl),
        .s_adr_o(s_adr_nl), .s_dat_o(s_dat_nl), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant_nl)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
        m_adr = '0; m_dat = '0; s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rstn = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        clear_inputs();
        rstn = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b11; s_dat_i = 32'h1234_5678;
        tick(); tick();
        n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_s_cyc: got %b expected 0", s_cyc_o); end
        n_checks++; if (s_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_s_stb: got %b expected 0", s_stb_o); end
        n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
        n_checks++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b expected 00", m_ack_o); end
        n_checks++; if (m_dat_o !== 32'h1234_5678) begin n_fail++; $display("FAIL reset_dat_pass: got %h expected 12345678", m_dat_o); end
        clear_inputs();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single_read;
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01; m_sel = 8'h0F;
        m_adr = {32'h0, 32'h3000_0004};
        #1;
        n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL read_pre_grant: got %b expected 00", grant_o); end
        tick();
        n_checks++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL read_grant: got %b expected 01", grant_o); end
        n_checks++; if (s_adr_o !== 32'h3000_0004) begin n_fail++; $display("FAIL read_adr: got %h expected 30000004", s_adr_o); end
        n_checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b110) begin n_fail++; $display("FAIL read_ctrl: got %b expected 110", {s_cyc_o, s_stb_o, s_we_o}); end
        n_checks++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL read_early_ack: got %b expected 00", m_ack_o); end
        tick();
        tick();
        s_ack = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (m_ack_o !== 2'b01) begin n_fail++; $display("FAIL read_ack: got %b expected 01", m_ack_o); end
        n_checks++; if (m_dat_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_data: got %h expected deadbeef", m_dat_o); end
        tick();
        s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
        #1;
        n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL read_cyc_drop: got %b expected 0", s_cyc_o); end
        tick();
        n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL read_release: got %b expected 00", grant_o); end
    endtask

    task automatic test_fairness;
        int       cnt0, cnt1, acks;
        logic [1:0] last;
        logic     want_idle;
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b11;
        cnt0 = 0; cnt1 = 0; acks = 0; last = 2'b10; want_idle = 1'b0;
        for (int c = 0; c < 500 && acks < 100; c++) begin
            tick();
            s_ack = 1'b0;
            if (want_idle) begin
                want_idle = 1'b0;
                n_checks++; if (grant_nl !== 2'b00) begin n_fail++; $display("FAIL fair_idle_gap: got %b expected 00", grant_nl); end
            end else if (grant_nl !== 2'b00) begin
                s_ack = 1'b1;
                #1;
                n_checks++; if (grant_nl === last) begin n_fail++; $display("FAIL fair_alternate: got %b expected not %b", grant_nl, last); end
                n_checks++; if (m_ack_nl !== grant_nl) begin n_fail++; $display("FAIL fair_ack_route: got %b expected %b", m_ack_nl, grant_nl); end
                if (grant_nl[0]) cnt0++;
                if (grant_nl[1]) cnt1++;
                last = grant_nl;
                acks++;
                want_idle = 1'b1;
            end
        end
        n_checks++; if (acks !== 100) begin n_fail++; $display("FAIL fair_total: got %0d expected 100", acks); end
        n_checks++; if (cnt0 !== 50) begin n_fail++; $display("FAIL fair_m0: got %0d expected 50", cnt0); end
        n_checks++; if (cnt1 !== 50) begin n_fail++; $display("FAIL fair_m1: got %0d expected 50", cnt1); end
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout;
        do_reset();
        m_cyc = 2'b10; m_stb = 2'b10;
        tick();
        for (int i = 1; i <= 16; i++) begin
            if (i > 1) tick();
            if (i < 16) begin
                n_checks++; if ({s_stb_o, m_err_o} !== 3'b100) begin n_fail++; $display("FAIL tmo_wait_%0d: got stb/err %b expected 100", i, {s_stb_o, m_err_o}); end
            end else begin
                n_checks++; if (m_err_o !== 2'b10) begin n_fail++; $display("FAIL tmo_err: got %b expected 10", m_err_o); end
                n_checks++; if (s_stb_o !== 1'b0) begin n_fail++; $display("FAIL tmo_stb_forced: got %b expected 0", s_stb_o); end
            end
        end
        tick();
        n_checks++; if ({s_stb_o, m_err_o} !== 3'b100) begin n_fail++; $display("FAIL tmo_after: got stb/err %b expected 100", {s_stb_o, m_err_o}); end
        repeat (15) tick();
        s_ack = 1'b1;
        #1;
        n_checks++; if (m_ack_o !== 2'b10) begin n_fail++; $display("FAIL tmo_coinc_ack: got %b expected 10", m_ack_o); end
        n_checks++; if (m_err_o !== 2'b00) begin n_fail++; $display("FAIL tmo_coinc_err: got %b expected 00", m_err_o); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_lock;
        do_reset();
        m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10; m_sel = 8'hF0;
        m_adr = {32'h3000_0010, 32'h0}; m_dat = {32'hA5A5_5A5A, 32'h0};
        tick();
        n_checks++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL lock_grant: got %b expected 10", grant_o); end
        n_checks++; if ({s_we_o, s_sel_o} !== 5'b11111) begin n_fail++; $display("FAIL lock_we_sel: got %b expected 11111", {s_we_o, s_sel_o}); end
        n_checks++; if (s_adr_o !== 32'h3000_0010) begin n_fail++; $display("FAIL lock_adr: got %h expected 30000010", s_adr_o); end
        n_checks++; if (s_dat_o !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL lock_wdata: got %h expected a5a55a5a", s_dat_o); end
        m_cyc = 2'b11; m_stb = 2'b11;
        for (int b = 0; b < 4; b++) begin
            s_ack = 1'b1;
            #1;
            n_checks++; if ({grant_o, m_ack_o} !== 4'b1010) begin n_fail++; $display("FAIL lock_beat_%0d: got grant/ack %b expected 1010", b, {grant_o, m_ack_o}); end
            tick();
        end
        s_ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01;
        #1;
        n_checks++; if ({grant_o, s_cyc_o} !== 3'b100) begin n_fail++; $display("FAIL lock_hold: got grant/cyc %b expected 100", {grant_o, s_cyc_o}); end
        tick();
        n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL lock_idle: got %b expected 00", grant_o); end
        tick();
        n_checks++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL lock_next: got %b expected 01", grant_o); end
        clear_inputs();
        tick();

        do_reset();
        m_cyc = 2'b10; m_stb = 2'b10;
        tick();
        m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
        #1;
        n_checks++; if (m_ack_nl !== 2'b10) begin n_fail++; $display("FAIL nolock_ack1: got %b expected 10", m_ack_nl); end
        tick();
        s_ack = 1'b0;
        n_checks++; if (grant_nl !== 2'b00) begin n_fail++; $display("FAIL nolock_idle1: got %b expected 00", grant_nl); end
        tick();
        n_checks++; if (grant_nl !== 2'b01) begin n_fail++; $display("FAIL nolock_switch: got %b expected 01", grant_nl); end
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        tick();
        n_checks++; if (grant_nl !== 2'b10) begin n_fail++; $display("FAIL nolock_back: got %b expected 10", grant_nl); end
        clear_inputs();
        tick();
    endtask

    task automatic test_abort;
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        n_checks++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL abort_grant: got %b expected 01", grant_o); end
        tick();
        m_cyc = 2'b10; m_stb = 2'b10; s_ack = 1'b1;
        #1;
        n_checks++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin n_fail++; $display("FAIL abort_bus: got %b expected 00", {s_cyc_o, s_stb_o}); end
        n_checks++; if ({m_ack_o, m_err_o} !== 4'b0000) begin n_fail++; $display("FAIL abort_resp: got %b expected 0000", {m_ack_o, m_err_o}); end
        tick();
        s_ack = 1'b0;
        n_checks++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL abort_idle: got %b expected 00", grant_o); end
        tick();
        n_checks++; if ({grant_o, s_cyc_o} !== 3'b101) begin n_fail++; $display("FAIL abort_next: got grant/cyc %b expected 101", {grant_o, s_cyc_o}); end
        rstn = 1'b0;
        #1;
        n_checks++; if ({grant_o, s_cyc_o, s_stb_o} !== 4'b0000) begin n_fail++; $display("FAIL midreset_drop: got %b expected 0000", {grant_o, s_cyc_o, s_stb_o}); end
        clear_inputs();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        clear_inputs();
        rstn = 1'b0;
        test_reset();
        test_single_read();
        test_fairness();
        test_timeout();
        test_lock();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
